// File: rtl/rx_pixel_writer.sv
// Frame-buffer write sequencer: buffers received 24-bit pixel words in a small
// FIFO and writes them to raster addresses through a req/ack memory port.
module rx_pixel_writer #(
  parameter int COLS   = 16,
  parameter int ROWS   = 12,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [23:0]              dato,
  input  logic                     frame_start,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [23:0]              mem_wdata,
  input  logic                     mem_ack,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [23:0]        fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_idx_s;
  logic [LVL_W-1:0]   count_r;
  logic [LVL_W-1:0]   count_nxt_s;
  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_r;
  logic               overflow_r;
  logic               frame_done_r;
  logic               full_s;
  logic               pop_s;
  logic               we_s;
  logic               drop_s;
  logic               last_col_s;
  logic               last_row_s;

  // FIFO control: frame_start flushes, and a coincident load becomes entry 0
  always_comb begin
    full_s     = (count_r == LVL_W'(DEPTH));
    pop_s      = (state_r == ST_REQ) && mem_ack && !frame_start;
    we_s       = load && (frame_start || !full_s || pop_s);
    drop_s     = load && full_s && !pop_s && !frame_start;
    last_col_s = (col_r == COL_W'(COLS - 1));
    last_row_s = (row_r == ROW_W'(ROWS - 1));
    if (frame_start) begin
      wr_idx_s    = {PTR_W{1'b0}};
      count_nxt_s = LVL_W'(load);
    end else begin
      wr_idx_s    = wr_ptr_r;
      count_nxt_s = count_r + LVL_W'(we_s) - LVL_W'(pop_s);
    end
  end

  // Next-state logic for the request sequencer
  always_comb begin
    state_nxt_s = state_r;
    if (frame_start) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_r != {LVL_W{1'b0}}) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (pop_s && (count_nxt_s == {LVL_W{1'b0}})) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (we_s) begin
      fifo_mem_r[wr_idx_s] <= dato;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_idx_s + PTR_W'(we_s);
      rd_ptr_r <= frame_start ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(pop_s);
      count_r  <= count_nxt_s;
    end
  end

  // Raster counters and end-of-frame pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r        <= {COL_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      frame_done_r <= 1'b0;
    end else if (frame_start) begin
      col_r        <= {COL_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= pop_s && last_col_s && last_row_s;
      if (pop_s) begin
        if (last_col_s) begin
          col_r <= {COL_W{1'b0}};
          row_r <= last_row_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end
    end
  end

  // Sticky drop flag, cleared by a new frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (frame_start) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign mem_req    = (state_r == ST_REQ);
  assign mem_addr   = mem_req ? (ADDR_W'(row_r) * ADDR_W'(COLS) + ADDR_W'(col_r))
                              : {ADDR_W{1'b0}};
  assign mem_wdata  = mem_req ? fifo_mem_r[rd_ptr_r] : 24'h000000;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;
  assign level      = count_r;
  assign busy       = (count_r != {LVL_W{1'b0}}) || mem_req;

endmodule

// File: tb/tb_rx_pixel_writer.sv
// Self-checking bench for rx_pixel_writer: directed scenarios plus random
// traffic, compared each cycle against a queue-based behavioural model.
module tb_rx_pixel_writer;

  localparam int COLS = 16, ROWS = 12, ADDR_W = 8, DEPTH = 4;
  localparam int NPIX = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst;
  logic              load, frame_start, mem_ack;
  logic [23:0]       dato;
  logic              mem_req, frame_done, overflow, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic [2:0]        level;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: pending words, next pixel index, flags
  logic [23:0] m_q[$];
  int          m_pix;
  bit          m_ovf, m_req, m_fd;

  always #5 clk = ~clk;

  rx_pixel_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load(load), .dato(dato), .frame_start(frame_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .frame_done(frame_done), .overflow(overflow), .level(level), .busy(busy)
  );

  task automatic model_reset();
    m_q.delete();
    m_pix = 0; m_ovf = 0; m_req = 0; m_fd = 0;
  endtask

  // one clock of the behavioural rules, using the inputs applied this cycle
  task automatic model_step();
    int sz0;
    bit pop;
    logic [23:0] tmp;
    if (frame_start) begin
      m_q.delete();
      if (load) m_q.push_back(dato);
      m_pix = 0; m_ovf = 0; m_req = 0; m_fd = 0;
    end else begin
      sz0 = m_q.size();
      pop = m_req && mem_ack;
      m_fd = 0;
      if (pop) begin
        tmp = m_q.pop_front();
        m_pix = (m_pix + 1) % NPIX;
        if (m_pix == 0) m_fd = 1;
      end
      if (load) begin
        if (sz0 < DEPTH || pop) m_q.push_back(dato);
        else m_ovf = 1;
      end
      m_req = m_req ? (m_q.size() != 0) : (sz0 != 0);
    end
  endtask

  function automatic logic [38:0] exp_vec();
    logic [7:0]  a;
    logic [23:0] w;
    logic        b;
    a = (m_req) ? 8'(m_pix) : 8'h00;
    w = (m_req && m_q.size() != 0) ? m_q[0] : 24'h000000;
    b = (m_q.size() != 0) || m_req;
    return {m_req, a, w, m_fd, m_ovf, 3'(m_q.size()), b};
  endfunction

  function automatic logic [38:0] obs_vec();
    logic [7:0]  a;
    logic [23:0] w;
    a = mem_req ? mem_addr : 8'h00;
    w = mem_req ? mem_wdata : 24'h000000;
    return {mem_req, a, w, frame_done, overflow, level, busy};
  endfunction

  task automatic drive(input logic l, input logic [23:0] d, input logic f, input logic a);
    load = l; dato = d; frame_start = f; mem_ack = a;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    model_reset();
    #2;
    n_checks++;
    if ({mem_req, mem_addr, mem_wdata, frame_done, overflow, level, busy} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0", obs_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    advance();
  endtask

  task automatic test_single_word();
    int req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, 24'hA1B2C3, 1'b0, 1'b1);
      else        drive(1'b0, 24'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      if (mem_req) req_cycles++;
      if (i == 2) begin
        n_checks++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 8'h00, 24'hA1B2C3}) begin
          n_fail++;
          $display("FAIL single_write got %h required %h",
                   {mem_req, mem_addr, mem_wdata}, {1'b1, 8'h00, 24'hA1B2C3});
        end
      end
      advance();
    end
    n_checks++;
    if (req_cycles != 1 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_req_len got %0d cycles level %0d required 1 and 0", req_cycles, level);
    end
  endtask

  task automatic test_stall();
    logic [23:0] words [3];
    int n_wr = 0;
    int last_wr_cyc = -1;
    for (int k = 0; k < 3; k++) words[k] = 24'($urandom);
    for (int i = -1; i < 14; i++) begin
      if (i < 0)      drive(1'b0, 24'h0, 1'b1, 1'b0);
      else if (i < 3) drive(1'b1, words[i], 1'b0, 1'b0);
      else            drive(1'b0, 24'h0, 1'b0, i >= 7);
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      if (mem_req && mem_ack && i >= 0) begin
        n_checks++;
        if (n_wr > 2 || mem_addr !== 8'(n_wr) || mem_wdata !== words[n_wr % 3] ||
            (n_wr > 0 && i != last_wr_cyc + 1)) begin
          n_fail++;
          $display("FAIL stall_write %0d got addr %0d data %h", n_wr, mem_addr, mem_wdata);
        end
        n_wr++;
        last_wr_cyc = i;
      end
      advance();
    end
    n_checks++;
    if (n_wr != 3 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_count got %0d writes level %0d required 3 and 0", n_wr, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = -1; i < 8; i++) begin
      if (i < 0)      drive(1'b0, 24'h0, 1'b1, 1'b0);
      else if (i < 5) drive(1'b1, 24'($urandom), 1'b0, 1'b0);
      else            drive(1'b0, 24'h0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL overflow cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
    n_checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_full got level %0d ovf %b required 4 and 1", level, overflow);
    end
    drive(1'b0, 24'h0, 1'b1, 1'b0);
    advance();
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0 || level !== 3'd0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear got ovf %b level %0d req %b required 0 0 0",
               overflow, level, mem_req);
    end
    advance();
  endtask

  task automatic test_frame_wrap();
    int n_wr = 0;
    int n_fd = 0;
    for (int i = -1; i < NPIX + 6; i++) begin
      if (i < 0)          drive(1'b0, 24'h0, 1'b1, 1'b1);
      else if (i <= NPIX) drive(1'b1, 24'($urandom), 1'b0, 1'b1);
      else                drive(1'b0, 24'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      if (frame_done) begin
        n_fd++;
        n_checks++;
        if (n_wr != NPIX) begin
          n_fail++;
          $display("FAIL wrap_done_time got %0d writes before pulse required %0d", n_wr, NPIX);
        end
      end
      if (mem_req && mem_ack && i >= 0) begin
        n_checks++;
        if (mem_addr !== 8'(n_wr % NPIX)) begin
          n_fail++;
          $display("FAIL wrap_addr write %0d got %0d required %0d", n_wr, mem_addr, n_wr % NPIX);
        end
        n_wr++;
      end
      advance();
    end
    n_checks++;
    if (n_fd != 1 || n_wr != NPIX + 1) begin
      n_fail++;
      $display("FAIL wrap_totals got %0d pulses %0d writes required 1 and %0d", n_fd, n_wr, NPIX + 1);
    end
  endtask

  task automatic test_frame_start_mid();
    logic [23:0] w_new;
    int n_wr = 0;
    w_new = 24'($urandom);
    for (int i = -1; i < 10; i++) begin
      if (i < 0)       drive(1'b0, 24'h0, 1'b1, 1'b0);
      else if (i == 0) drive(1'b1, 24'h111111, 1'b0, 1'b0);
      else if (i == 1) drive(1'b1, 24'h222222, 1'b0, 1'b0);
      else if (i == 2) drive(1'b1, 24'h333333, 1'b0, 1'b0);
      else if (i == 3) drive(1'b0, 24'h0, 1'b0, 1'b0);
      else if (i == 4) drive(1'b1, w_new, 1'b1, 1'b1);
      else             drive(1'b0, 24'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fs_mid cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        n_checks++;
        if (mem_req !== 1'b1) begin
          n_fail++;
          $display("FAIL fs_mid_pending got req %b required 1", mem_req);
        end
      end
      if (i > 4 && mem_req && mem_ack) begin
        n_checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== w_new || n_wr != 0) begin
          n_fail++;
          $display("FAIL fs_mid_write got addr %0d data %h n %0d required 0 %h 0",
                   mem_addr, mem_wdata, n_wr, w_new);
        end
        n_wr++;
      end
      advance();
    end
    n_checks++;
    if (n_wr != 1) begin
      n_fail++;
      $display("FAIL fs_mid_count got %0d writes required 1", n_wr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 1) == 1), 24'($urandom), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 6));
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int n_wr = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 24'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_mid_pre cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pending got req %b required 1", mem_req);
    end
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({mem_req, mem_addr, mem_wdata, frame_done, overflow, level, busy} !== 39'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async got %h required 0", obs_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    advance();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, 24'h5A5A5A, 1'b0, 1'b1);
      else        drive(1'b0, 24'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_mid_post cyc %0d got %h required %h", i, obs_vec(), exp_vec());
      end
      if (mem_req && mem_ack) begin
        n_checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 24'h5A5A5A) begin
          n_fail++;
          $display("FAIL rst_mid_write got addr %0d data %h required 0 5a5a5a", mem_addr, mem_wdata);
        end
        n_wr++;
      end
      advance();
    end
    n_checks++;
    if (n_wr != 1) begin
      n_fail++;
      $display("FAIL rst_mid_count got %0d writes required 1", n_wr);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall();
    test_overflow();
    test_frame_wrap();
    test_frame_start_mid();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
